// File: rtl/blake3_chunk_seq.sv
// blake3_chunk_seq -- chunk sequencer in front of the HashGen compression core.
//
// Takes a chunk as a stream of 64-byte message blocks (valid/ready) and issues
// them one at a time to HashGen. Each block's output CV is chained into the next
// block's H input. The final CV is returned on a valid/ready result port.
//
// Ports:
//   Clk, Rst                   clock, synchronous active-high reset
//   Blk_Vld_I/Blk_Rdy_O        block handshake; Blk_Msg_I (m0 in [31:0]),
//                              Blk_Len_I (0..64), Blk_Last_I, Root_I (first block only)
//   Strt_O, BL_O, CS/CE/ROOT_flg_O, H_O, Msg_O   HashGen request side
//   Vld_I, H_I                 HashGen result side
//   Res_Vld_O/Res_Rdy_I, Res_H_O                 chunk result
//   Ovf_O                      sticky: chunk truncated at MAX_BLKS
//   Err_O                      sticky: HashGen timeout
//
// Optional feature: define HASH_TIMEOUT_EN to enable the WAIT-state watchdog
// (TIMEOUT_CYC cycles). Without it Err_O is tied low and WAIT waits forever.

`ifndef IV_0
`define IV_0 32'h6A09E667
`define IV_1 32'hBB67AE85
`define IV_2 32'h3C6EF372
`define IV_3 32'hA54FF53A
`define IV_4 32'h510E527F
`define IV_5 32'h9B05688C
`define IV_6 32'h1F83D9AB
`define IV_7 32'h5BE0CD19
`endif

module blake3_chunk_seq #(
  parameter int MAX_BLKS    = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Blk_Vld_I,
  output logic         Blk_Rdy_O,
  input  logic [511:0] Blk_Msg_I,
  input  logic [6:0]   Blk_Len_I,
  input  logic         Blk_Last_I,
  input  logic         Root_I,
  output logic         Strt_O,
  output logic [31:0]  BL_O,
  output logic         CS_flg_O,
  output logic         CE_flg_O,
  output logic         ROOT_flg_O,
  output logic [255:0] H_O,
  output logic [511:0] Msg_O,
  input  logic         Vld_I,
  input  logic [255:0] H_I,
  output logic         Res_Vld_O,
  input  logic         Res_Rdy_I,
  output logic [255:0] Res_H_O,
  output logic         Ovf_O,
  output logic         Err_O
);

  localparam int IW = $clog2(MAX_BLKS);
  localparam logic [255:0] IV = {`IV_7, `IV_6, `IV_5, `IV_4, `IV_3, `IV_2, `IV_1, `IV_0};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESULT} state_e;

  state_e         state_q, state_d;
  logic [255:0]   h_q, h_d, res_h_q, res_h_d;
  logic [511:0]   msg_q, msg_d;
  logic [6:0]     bl_q, bl_d;
  logic           cs_q, cs_d, ce_q, ce_d, root_q, root_d;
  logic           rlat_q, rlat_d, ovf_q, ovf_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           tmo;
  logic           last_idx, rsel;
  logic [6:0]     blen_sat;

`ifdef HASH_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          err_q;

  // Counter restarts on every WAIT entry (ISSUE always precedes WAIT).
  assign tmo = (state_q == S_WAIT) && !Vld_I && (cnt_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_ISSUE)     cnt_d = '0;
    else if (state_q == S_WAIT) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_q | tmo;
    end
  end

  assign Err_O = err_q;
`else
  assign tmo   = 1'b0;
  assign Err_O = 1'b0;
`endif

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (Blk_Vld_I) state_d = S_ISSUE;
      S_ISSUE:  state_d = S_WAIT;
      S_WAIT: begin
        if (Vld_I)    state_d = ce_q ? S_RESULT : S_IDLE;
        else if (tmo) state_d = S_IDLE;
      end
      S_RESULT: if (Res_Rdy_I) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; ready is masked while reset is held.
  always_comb begin
    Blk_Rdy_O = (state_q == S_IDLE) && !Rst;
    Strt_O    = (state_q == S_ISSUE);
    Res_Vld_O = (state_q == S_RESULT);
  end

  // Datapath next-state
  assign last_idx = (idx_q == IW'(MAX_BLKS - 1));
  assign blen_sat = (Blk_Len_I > 7'd64) ? 7'd64 : Blk_Len_I;
  // Root is only taken from the first block of a chunk.
  assign rsel     = (idx_q == '0) ? Root_I : rlat_q;

  always_comb begin
    h_d     = h_q;
    res_h_d = res_h_q;
    msg_d   = msg_q;
    bl_d    = bl_q;
    cs_d    = cs_q;
    ce_d    = ce_q;
    root_d  = root_q;
    rlat_d  = rlat_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: if (Blk_Vld_I) begin
        msg_d  = Blk_Msg_I;
        bl_d   = blen_sat;
        cs_d   = (idx_q == '0);
        ce_d   = Blk_Last_I | last_idx;
        rlat_d = rsel;
        root_d = (Blk_Last_I | last_idx) & rsel;
        if (last_idx && !Blk_Last_I) ovf_d = 1'b1;
      end
      S_WAIT: begin
        if (Vld_I) begin
          if (ce_q) begin
            res_h_d = H_I;
            h_d     = IV;
            idx_d   = '0;
          end else begin
            h_d     = H_I;
            idx_d   = idx_q + 1'b1;
          end
        end else if (tmo) begin
          // Abandon the chunk; next block starts a fresh one.
          h_d   = IV;
          idx_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      h_q     <= IV;
      res_h_q <= '0;
      msg_q   <= '0;
      bl_q    <= '0;
      cs_q    <= 1'b0;
      ce_q    <= 1'b0;
      root_q  <= 1'b0;
      rlat_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      h_q     <= h_d;
      res_h_q <= res_h_d;
      msg_q   <= msg_d;
      bl_q    <= bl_d;
      cs_q    <= cs_d;
      ce_q    <= ce_d;
      root_q  <= root_d;
      rlat_q  <= rlat_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign H_O        = h_q;
  assign Msg_O      = msg_q;
  assign BL_O       = {25'd0, bl_q};
  assign CS_flg_O   = cs_q;
  assign CE_flg_O   = ce_q;
  assign ROOT_flg_O = root_q;
  assign Res_H_O    = res_h_q;
  assign Ovf_O      = ovf_q;

endmodule

// File: doc/blake3_chunk_seq.md
Name: blake3_chunk_seq

Overview:
- Initiator-side sequencer for the HashGen compression core.
- Accepts a chunk as a stream of 64-byte message blocks via valid/ready and drives HashGen's start/flag/chaining/message inputs, one block in flight at a time.
- Chains each block's output CV into the next block's H input and returns the final chunk chaining value.
- Sits between the miner's work/message buffer and HashGen.

Parameters:
- MAX_BLKS, 16: blocks per chunk (1024 B). Must be 2..16.
- TIMEOUT_CYC, 4096: watchdog limit in cycles; used only when the optional feature is enabled.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  synchronous, active-high reset.
- Blk_Vld_I  in  1  input block valid.
- Blk_Rdy_O  out  1  sequencer ready for a block.
- Blk_Msg_I  in  512  block words m0..m15; m0 in bits [31:0].
- Blk_Len_I  in  7  block byte length, 0..64.
- Blk_Last_I  in  1  final block of the chunk.
- Root_I  in  1  chunk is root; sampled with the first block only.
- Strt_O  out  1  one-cycle start pulse to HashGen.
- BL_O  out  32  block length to HashGen.
- CS_flg_O / CE_flg_O / ROOT_flg_O  out  1 each  chunk-start / chunk-end / root flags.
- H_O  out  256  chaining value to HashGen; word i in [32i+31:32i].
- Msg_O  out  512  message block to HashGen.
- Vld_I  in  1  HashGen result valid.
- H_I  in  256  HashGen output H0..H7.
- Res_Vld_O  out  1  chunk result valid.
- Res_Rdy_I  in  1  result consumer ready.
- Res_H_O  out  256  final chunk CV.
- Ovf_O  out  1  sticky: chunk truncated at MAX_BLKS.
- Err_O  out  1  sticky: timeout (optional feature only; otherwise tied 0).

Behaviour:
- Reset:
  - State IDLE.
  - Strt_O, Res_Vld_O, Ovf_O, Err_O = 0; Blk_Rdy_O = 0 during reset, 1 the first cycle after.
  - H_O = IV (`IV_0..`IV_7); Msg_O, BL_O, Res_H_O = 0; all flags 0; block index = 0.
- FSM states: IDLE, ISSUE, WAIT, RESULT.
- IDLE:
  - Blk_Rdy_O = 1.
  - On Blk_Vld_I & Blk_Rdy_O, register Msg, BL = min(Blk_Len_I, 64), and flags:
    - CS = (idx == 0).
    - CE = Blk_Last_I | (idx == MAX_BLKS-1).
    - ROOT = CE & root latch, where root latch = Root_I when idx == 0.
  - Go to ISSUE.
- ISSUE:
  - Strt_O = 1 for exactly one cycle.
  - All HashGen inputs are stable from this cycle until Vld_I is seen.
  - Go to WAIT.
- WAIT:
  - Blk_Rdy_O = 0.
  - On Vld_I, capture H_I.
  - If CE: Res_H_O = H_I, H_O = IV, idx = 0, go to RESULT.
  - Else: H_O = H_I, idx++, go to IDLE.
- RESULT:
  - Res_Vld_O = 1, held with Res_H_O stable until Res_Rdy_I.
  - On Res_Rdy_I (same cycle counts), go to IDLE; Res_Vld_O drops next cycle.
- Vld_I outside WAIT is ignored; it never alters H_O or state.
- Latency:
  - Accept at cycle t → Strt_O at t+1.
  - Vld_I at cycle v → next-block Blk_Rdy_O at v+1, or Res_Vld_O at v+1.
- Truncation: a block accepted at idx == MAX_BLKS-1 without Blk_Last_I is forced CE and sets Ovf_O. Ovf_O is cleared only by Rst.
- Zero-length block: legal only as the single block of an empty chunk (CS = CE = 1, BL = 0); passed through unchanged.
- Reset mid-operation: abort the chunk immediately and restore reset values. A HashGen Vld_I arriving later is ignored (state IDLE).
- Root_I on blocks with idx > 0 is ignored.

Optional Feature:
- Macro: HASH_TIMEOUT_EN.
- Enabled: a counter runs in WAIT. If TIMEOUT_CYC cycles elapse without Vld_I:
  - Err_O = 1 (sticky until Rst).
  - Chunk aborted: H_O = IV, idx = 0, go to IDLE; no result produced.
  - The counter clears on every entry to WAIT.
- Disabled: no counter, Err_O tied 0, WAIT waits indefinitely.

Test Plan:
- Single block, Msg[j] = j*0x55, len 64, Last = 1, Root = 0 → one Strt_O pulse with BL_O = 64, CS = 1, CE = 1, ROOT = 0, H_O = IV. Res_H_O equals the HashGen model output and Res_Vld_O rises the cycle after Vld_I.
- Three-block chunk (64, 64, 10 bytes), Root_I = 1 on the first block → flags (CS, CE, ROOT) = (1,0,0), (0,0,0), (0,1,1). Blocks 2 and 3 use the previous H_I as H_O. BL_O = 64, 64, 10.
- 17 blocks with Last never asserted, MAX_BLKS = 16 → block 16 issued with CE = 1 and Ovf_O = 1. Block 17 starts a new chunk with CS = 1 and H_O = IV.
- Spurious Vld_I in IDLE, and Rst asserted mid-WAIT → no state or H_O change from the stray Vld_I. After Rst, all outputs are at reset values and Blk_Rdy_O = 1 the cycle after Rst deasserts.
- Res_Rdy_I held low for 5 cycles → Res_Vld_O and Res_H_O stable for all 5 cycles, Blk_Rdy_O = 0 throughout. Release → IDLE next cycle.
- HASH_TIMEOUT_EN, TIMEOUT_CYC = 8, HashGen stub never asserts Vld_I → Err_O = 1 after 8 WAIT cycles, then IDLE with Blk_Rdy_O = 1 and no Res_Vld_O.
